pillars_stream_obstacle: RTL and testbench

//  Parametrised successor to the single horizontal pillar obstacle. Streams up to N_PILLARS vertical

---
 rtl/pillars_stream_obstacle_pkg.sv | 24 ++
 rtl/gap_lfsr.sv | 20 ++
 rtl/pillars_stream_obstacle.sv | 190 +++++++++++++++++++
 tb/tb_pillars_stream_obstacle.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pillars_stream_obstacle_pkg.sv
// Shared definitions for the obstacle chain: FSM state encoding, default
// arena bounds, colour constants and the gap LFSR step function.
package pillars_stream_obstacle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } obst_state_t;

    localparam int DEF_ARENA_L = 352;
    localparam int DEF_ARENA_R = 671;
    localparam int DEF_ARENA_T = 317;
    localparam int DEF_ARENA_B = 617;

    localparam logic [11:0] COLOR_WHITE = 12'hfff;
    localparam logic [7:0]  LFSR_SEED   = 8'hA5;

    // Fibonacci step, taps 8,6,5,4 (bits 7,5,4,3), shifting towards the MSB
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/gap_lfsr.sv
// 8-bit Fibonacci LFSR used to pick pillar gap positions.
// Ports: pclk/rst clock and async active-high reset, adv steps the register
// by one, value is the current state (never zero given a nonzero SEED).
module gap_lfsr
    import pillars_stream_obstacle_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       adv,
    output logic [7:0] value
);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst)      value <= SEED;
        else if (adv) value <= lfsr_step(value);
    end

endmodule

// File: rtl/pillars_stream_obstacle.sv
// Streams up to N_PILLARS vertical pillars across the arena, each with a
// random safe gap. Slots only change on a frame-locked step tick, so a frame
// never shows a half-moved pillar.
// Ports: pclk/rst clock and async active-high reset; hcount_in/vcount_in/
// rgb_in current pixel; menu_on/play_selected abort controls; selected and
// done_in arm the obstacle; rgb_out/obstacle_x/obstacle_y registered pixel
// result; working high while running; done one-cycle completion pulse.
module pillars_stream_obstacle
    import pillars_stream_obstacle_pkg::*;
#(
    parameter logic [3:0]  SELECT_CODE = 4'b0000,
    parameter int          N_PILLARS   = 4,
    parameter int          WAVES       = 10,
    parameter int          PILLAR_W    = 20,
    parameter int          GAP_H       = 80,
    parameter int          SPACING     = 120,
    parameter int          DX          = 2,
    parameter int          FRAME_DIV   = 1,
    parameter int          DIR         = 0,
    parameter int          ARENA_L     = DEF_ARENA_L,
    parameter int          ARENA_R     = DEF_ARENA_R,
    parameter int          ARENA_T     = DEF_ARENA_T,
    parameter int          ARENA_B     = DEF_ARENA_B,
    parameter logic [11:0] COLOR       = COLOR_WHITE
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic [11:0] rgb_in,
    input  logic        menu_on,
    input  logic        play_selected,
    input  logic [3:0]  selected,
    input  logic        done_in,
    output logic [11:0] rgb_out,
    output logic [11:0] obstacle_x,
    output logic [11:0] obstacle_y,
    output logic        working,
    output logic        done
);

    localparam int GAP_RANGE = ARENA_B - ARENA_T + 1 - GAP_H;
    localparam logic signed [12:0] X_L     = 13'(ARENA_L);
    localparam logic signed [12:0] X_R     = 13'(ARENA_R);
    localparam logic signed [12:0] W_M1    = 13'(PILLAR_W - 1);
    localparam logic signed [12:0] STEP    = 13'(DX);
    localparam logic signed [12:0] SPAWN_X = (DIR != 0) ? 13'(ARENA_L - PILLAR_W) : 13'(ARENA_R + 1);
    localparam logic [11:0]        GAP_M1  = 12'(GAP_H - 1);

    obst_state_t state;
    logic [3:0]  div_cnt;
    logic [7:0]  spawned;
    logic [11:0] travel;      // distance moved by the newest pillar, saturates at SPACING
    logic        first_pend;  // first tick of a run always spawns
    logic [7:0]  lfsr;

    logic [N_PILLARS-1:0] act_q, act_mv, act_nx, free_oh, spawn_vec, hit;
    logic signed [12:0]   x_q  [N_PILLARS];
    logic signed [12:0]   x_mv [N_PILLARS];
    logic [11:0]          gt_q [N_PILLARS];

    logic        frame_start, tick, abort, arm, want, do_spawn, fin, in_arena, hit_any;
    logic [12:0] travel_sum;
    logic [11:0] travel_mv, gap_val;
    logic [7:0]  spawned_nx;
    logic signed [12:0] hx;

    assign frame_start = (hcount_in == 12'd0) && (vcount_in == 12'd0);
    assign abort       = menu_on || !play_selected;
    assign arm         = (state == ST_IDLE) && done_in && play_selected && (selected == SELECT_CODE);
    assign tick        = (state == ST_RUN) && frame_start && (div_cnt == 4'd0);
    assign hx          = $signed({1'b0, hcount_in});

    // Per-slot move/retire (after-move view) and draw (current view)
    for (genvar i = 0; i < N_PILLARS; i++) begin : g_slot
        assign x_mv[i]   = (DIR != 0) ? x_q[i] + STEP : x_q[i] - STEP;
        assign act_mv[i] = act_q[i] && (x_mv[i] + W_M1 >= X_L) && (x_mv[i] <= X_R);
        assign hit[i]    = act_q[i] && (hx >= x_q[i]) && (hx <= x_q[i] + W_M1) &&
                           !((vcount_in >= gt_q[i]) && (vcount_in <= gt_q[i] + GAP_M1));
    end

    // Lowest free slot after retirement; walking downwards lets slot 0 win
    always_comb begin
        free_oh = '0;
        for (int i = N_PILLARS - 1; i >= 0; i--) begin
            if (!act_mv[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
        end
    end

    assign travel_sum = {1'b0, travel} + 13'(DX);
    assign travel_mv  = (travel_sum >= 13'(SPACING)) ? 12'(SPACING) : travel_sum[11:0];
    assign want       = (first_pend || (travel_sum >= 13'(SPACING))) && (spawned < 8'(WAVES));
    // A blocked spawn stays wanted (travel saturates) until a slot frees up
    assign do_spawn   = tick && !abort && want && (|free_oh);
    assign spawn_vec  = do_spawn ? free_oh : '0;
    assign act_nx     = act_mv | spawn_vec;
    assign spawned_nx = spawned + {7'd0, do_spawn};
    assign fin        = tick && !abort && (spawned_nx == 8'(WAVES)) && (act_nx == '0);
    assign gap_val    = 12'(ARENA_T + (int'(lfsr) % GAP_RANGE));

    assign in_arena = (hx >= X_L) && (hx <= X_R) &&
                      (vcount_in >= 12'(ARENA_T)) && (vcount_in <= 12'(ARENA_B));
    assign hit_any  = (state == ST_RUN) && in_arena && (|hit);

    gap_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .pclk  (pclk),
        .rst   (rst),
        .adv   (do_spawn),
        .value (lfsr)
    );

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            act_q <= '0;
            for (int i = 0; i < N_PILLARS; i++) begin
                x_q[i]  <= '0;
                gt_q[i] <= '0;
            end
        end else if ((state == ST_RUN) && abort) begin
            act_q <= '0;
        end else if (tick) begin
            act_q <= act_nx;
            for (int i = 0; i < N_PILLARS; i++) begin
                if (spawn_vec[i]) begin
                    x_q[i]  <= SPAWN_X;
                    gt_q[i] <= gap_val;
                end else if (act_q[i]) begin
                    x_q[i]  <= x_mv[i];
                end
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            working    <= 1'b0;
            done       <= 1'b0;
            div_cnt    <= '0;
            spawned    <= '0;
            travel     <= '0;
            first_pend <= 1'b0;
            rgb_out    <= '0;
            obstacle_x <= '0;
            obstacle_y <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state      <= ST_RUN;
                        working    <= 1'b1;
                        div_cnt    <= '0;
                        spawned    <= '0;
                        travel     <= '0;
                        first_pend <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        working <= 1'b0;
                    end else begin
                        if (frame_start)
                            div_cnt <= (div_cnt == 4'(FRAME_DIV - 1)) ? 4'd0 : div_cnt + 4'd1;
                        if (tick) begin
                            spawned <= spawned_nx;
                            travel  <= do_spawn ? 12'd0 : travel_mv;
                            if (do_spawn) first_pend <= 1'b0;
                            if (fin) begin
                                state   <= ST_FINISH;
                                working <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
            rgb_out    <= hit_any ? COLOR : rgb_in;
            obstacle_x <= hit_any ? hcount_in : 12'd0;
            obstacle_y <= hit_any ? vcount_in : 12'd0;
        end
    end

endmodule

// File: tb/tb_pillars_stream_obstacle.sv
// Bench for pillars_stream_obstacle: three instances (defaults; one slot with
// short spacing; left-to-right with frame divider) armed one at a time via
// distinct select codes, checked against a queue-based pillar model.
module tb_pillars_stream_obstacle;

    localparam int AL = 352, AR = 671, AT = 317, AB = 617;
    localparam int PW = 20, GH = 80, DXB = 2;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] hcount, vcount, rgb_in;
    logic        menu_on, play_sel, done_in;
    logic [3:0]  selected;
    logic [11:0] rgb_o [3];
    logic [11:0] ox    [3];
    logic [11:0] oy    [3];
    logic        wk    [3];
    logic        dn    [3];

    always #5 pclk = ~pclk;

    pillars_stream_obstacle #(.SELECT_CODE(4'd0)) u0 (
        .pclk(pclk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount), .rgb_in(rgb_in),
        .menu_on(menu_on), .play_selected(play_sel), .selected(selected), .done_in(done_in),
        .rgb_out(rgb_o[0]), .obstacle_x(ox[0]), .obstacle_y(oy[0]), .working(wk[0]), .done(dn[0]));

    pillars_stream_obstacle #(.SELECT_CODE(4'd1), .N_PILLARS(1), .SPACING(16), .WAVES(3)) u1 (
        .pclk(pclk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount), .rgb_in(rgb_in),
        .menu_on(menu_on), .play_selected(play_sel), .selected(selected), .done_in(done_in),
        .rgb_out(rgb_o[1]), .obstacle_x(ox[1]), .obstacle_y(oy[1]), .working(wk[1]), .done(dn[1]));

    pillars_stream_obstacle #(.SELECT_CODE(4'd2), .DIR(1), .FRAME_DIV(3), .WAVES(2)) u2 (
        .pclk(pclk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount), .rgb_in(rgb_in),
        .menu_on(menu_on), .play_selected(play_sel), .selected(selected), .done_in(done_in),
        .rgb_out(rgb_o[2]), .obstacle_x(ox[2]), .obstacle_y(oy[2]), .working(wk[2]), .done(dn[2]));

    int n_chk = 0, n_pass = 0;
    int cur = 0;

    // Reference model: list of live pillars (left edge, gap top) plus counters
    int m_n, m_waves, m_spacing, m_fdiv, m_dir;
    int px[$];
    int pg[$];
    int m_spawned, m_dist, m_frames;
    bit m_first, m_run;
    int m_lfsr [3];

    function automatic int lfsr_adv(input int l);
        return ((l << 1) | (((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1)) & 255;
    endfunction

    function automatic bit model_hit(input int h, input int v);
        if (!m_run || h < AL || h > AR || v < AT || v > AB) return 1'b0;
        foreach (px[k])
            if (h >= px[k] && h <= px[k] + PW - 1 && !(v >= pg[k] && v <= pg[k] + GH - 1)) return 1'b1;
        return 1'b0;
    endfunction

    // One frame start seen by the model; returns 1 when the run completes
    function automatic bit model_frame();
        bit is_tick;
        if (!m_run) return 1'b0;
        if (menu_on || !play_sel) begin
            m_run = 1'b0;
            px.delete();
            pg.delete();
            return 1'b0;
        end
        is_tick  = (m_frames % m_fdiv) == 0;
        m_frames = m_frames + 1;
        if (!is_tick) return 1'b0;
        for (int k = px.size() - 1; k >= 0; k--) begin
            px[k] = px[k] + (m_dir != 0 ? DXB : -DXB);
            if (px[k] + PW - 1 < AL || px[k] > AR) begin
                px.delete(k);
                pg.delete(k);
            end
        end
        m_dist = m_dist + DXB;
        if (m_spawned < m_waves && (m_first || m_dist >= m_spacing) && px.size() < m_n) begin
            px.push_back(m_dir != 0 ? AL - PW : AR + 1);
            pg.push_back(AT + m_lfsr[cur] % (AB - AT + 1 - GH));
            m_lfsr[cur] = lfsr_adv(m_lfsr[cur]);
            m_spawned   = m_spawned + 1;
            m_dist      = 0;
            m_first     = 1'b0;
        end
        if (m_spawned == m_waves && px.size() == 0) begin
            m_run = 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic probe(input int h, input int v);
        bit          eh;
        logic [11:0] rin;
        hcount = 12'(h);
        vcount = 12'(v);
        rin    = 12'($urandom);
        rgb_in = rin;
        eh     = model_hit(h, v);
        @(posedge pclk); #1;
        n_chk++;
        if (rgb_o[cur] !== (eh ? 12'hfff : rin))
            $display("FAIL probe_rgb h=%0d v=%0d got %h want %h", h, v, rgb_o[cur], eh ? 12'hfff : rin);
        else n_pass++;
        n_chk++;
        if (ox[cur] !== (eh ? 12'(h) : 12'd0) || oy[cur] !== (eh ? 12'(v) : 12'd0))
            $display("FAIL probe_obs h=%0d v=%0d got (%0d,%0d) want hit=%0d", h, v, ox[cur], oy[cur], eh);
        else n_pass++;
        n_chk++;
        if (wk[cur] !== m_run || dn[cur] !== 1'b0)
            $display("FAIL probe_status got working=%b done=%b want working=%b done=0", wk[cur], dn[cur], m_run);
        else n_pass++;
    endtask

    task automatic tick_frame();
        bit          ef;
        logic [11:0] rin;
        hcount = 12'd0;
        vcount = 12'd0;
        rin    = 12'($urandom);
        rgb_in = rin;
        ef     = model_frame();
        @(posedge pclk); #1;
        n_chk++;
        if (rgb_o[cur] !== rin || ox[cur] !== 12'd0 || oy[cur] !== 12'd0)
            $display("FAIL tick_pixel got rgb=%h obs=(%0d,%0d) want rgb=%h obs=0", rgb_o[cur], ox[cur], oy[cur], rin);
        else n_pass++;
        n_chk++;
        if (dn[cur] !== ef || wk[cur] !== m_run)
            $display("FAIL tick_status got done=%b working=%b want done=%b working=%b", dn[cur], wk[cur], ef, m_run);
        else n_pass++;
    endtask

    task automatic frame(input int np);
        tick_frame();
        for (int p = 0; p < np; p++) begin
            int h, v, k;
            if (px.size() > 0 && $urandom_range(3) != 0) begin
                k = int'($urandom_range(px.size() - 1));
                case ($urandom_range(4))
                    0: h = px[k] - 1;
                    1: h = px[k];
                    2: h = px[k] + PW - 1;
                    3: h = px[k] + PW;
                    default: h = px[k] + int'($urandom_range(PW - 1));
                endcase
                case ($urandom_range(5))
                    0: v = pg[k] - 1;
                    1: v = pg[k];
                    2: v = pg[k] + GH - 1;
                    3: v = pg[k] + GH;
                    4: v = ($urandom_range(1) != 0) ? AT - 1 : AB + 1;
                    default: v = int'($urandom_range(AB, AT));
                endcase
            end else begin
                h = int'($urandom_range(700, 330));
                v = int'($urandom_range(640, 300));
            end
            probe(h, v);
        end
    endtask

    task automatic run_until_done(input int max_frames);
        int f = 0;
        while (m_run && f < max_frames) begin
            frame(3);
            f++;
        end
        n_chk++;
        if (m_run) $display("FAIL run_timeout still running after %0d frames want done", f);
        else n_pass++;
    endtask

    task automatic arm(input int c);
        cur       = c;
        m_n       = (c == 1) ? 1 : 4;
        m_waves   = (c == 0) ? 10 : (c == 1) ? 3 : 2;
        m_spacing = (c == 1) ? 16 : 120;
        m_fdiv    = (c == 2) ? 3 : 1;
        m_dir     = (c == 2) ? 1 : 0;
        selected  = 4'(c);
        play_sel  = 1'b1;
        done_in   = 1'b1;
        hcount    = 12'd5;
        vcount    = 12'd5;
        rgb_in    = 12'd0;
        @(posedge pclk); #1;
        done_in   = 1'b0;
        m_run = 1'b1; m_spawned = 0; m_dist = 0; m_first = 1'b1; m_frames = 0;
        px.delete();
        pg.delete();
        n_chk++;
        if (wk[cur] !== 1'b1 || dn[cur] !== 1'b0)
            $display("FAIL arm_working inst=%0d got working=%b done=%b want 1/0", c, wk[cur], dn[cur]);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if ({rgb_o[k], ox[k], oy[k], wk[k], dn[k]} !== '0)
                $display("FAIL reset_outputs inst=%0d got rgb=%h obs=(%0d,%0d) w=%b d=%b want 0",
                         k, rgb_o[k], ox[k], oy[k], wk[k], dn[k]);
            else n_pass++;
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) m_lfsr[k] = 8'hA5;
    endtask

    task automatic test_arm();
        arm(0);
        tick_frame();        // spawns at x=672, still clipped
        probe(671, 617);
        probe(672, 617);
        tick_frame();        // x=670, two columns visible
        probe(670, 617);
        probe(669, 617);
    endtask

    task automatic test_pixel();
        int x, g;
        repeat (10) frame(2);
        x = px[0];
        g = pg[0];
        probe(x, g - 1);
        probe(x, g);
        probe(x + PW - 1, g + GH - 1);
        probe(x + PW - 1, g + GH);
    endtask

    task automatic test_waves();
        run_until_done(1500);
        repeat (4) probe(int'($urandom_range(AR, AL)), int'($urandom_range(AB, AT)));
    endtask

    task automatic test_deferred();
        arm(1);
        run_until_done(1500);
        probe(500, 617);
    endtask

    task automatic test_abort();
        int old_x;
        arm(0);
        repeat (30) frame(2);
        old_x   = px[0];
        menu_on = 1'b1;      // abort coincides with a tick
        tick_frame();
        menu_on = 1'b0;
        probe(old_x, 617);
        arm(0);
        frame(1);
        probe(old_x, 617);   // old pillar gone after re-arm
        repeat (3) frame(2);
        probe(400, 400);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({rgb_o[cur], ox[cur], oy[cur], wk[cur], dn[cur]} !== '0)
            $display("FAIL async_reset got rgb=%h obs=(%0d,%0d) w=%b d=%b want 0",
                     rgb_o[cur], ox[cur], oy[cur], wk[cur], dn[cur]);
        else n_pass++;
        m_run = 1'b0;
        px.delete();
        pg.delete();
        for (int k = 0; k < 3; k++) m_lfsr[k] = 8'hA5;
        repeat (2) @(posedge pclk);
        #1 rst = 1'b0;
    endtask

    task automatic test_dir();
        arm(2);
        repeat (28) frame(1); // 10 ticks: x = 332 + 18 = 350
        probe(351, 617);
        probe(352, 617);
        probe(369, 617);
        probe(370, 617);
        run_until_done(3000);
    endtask

    initial begin
        hcount = '0; vcount = '0; rgb_in = '0;
        menu_on = 1'b0; play_sel = 1'b0; done_in = 1'b0; selected = '0;
        m_run = 1'b0;
        test_reset();
        test_arm();
        test_pixel();
        test_waves();
        test_deferred();
        test_abort();
        test_dir();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
